// File: rtl/lbuf_pkg.sv
// Shared types for the multi-line buffer: flush/run state encoding and the
// length of the memory-clearing sweep.
package lbuf_pkg;

   typedef enum logic [0:0] {
      ST_FLUSH = 1'b0,
      ST_RUN   = 1'b1
   } lbuf_state_e;

   // One write per address, so the sweep takes exactly one line of cycles.
   function automatic int unsigned lbuf_sweep_len(input int unsigned max_width);
      return max_width;
   endfunction

endpackage

// File: rtl/lbuf_line_ram.sv
// One line of pixel storage: simple dual-port RAM with a registered read that
// returns the old contents when read and write hit the same address.
module lbuf_line_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 128,
   parameter int AW     = 7
) (
   input  logic              clk,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (re_i) rdata_q <= mem_q[raddr_i];
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/multi_line_buffer.sv
// Streaming column generator over ROWS image lines. Define LBUF_FLUSH_SWEEP_EN
// to zero the line memories with a sweep after reset/clear; otherwise rows that
// do not exist yet are masked to zero and the block is ready one cycle later.
module multi_line_buffer
   import lbuf_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int MAX_WIDTH = 128,
   parameter int ROWS      = 3,
   parameter int X_W       = 11,
   parameter int Y_W       = 10
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic [$clog2(MAX_WIDTH):0]   img_width,
   input  logic [DATA_W-1:0]            pixel_in,
   input  logic                         pixel_valid,
   output logic                         pixel_ready,
   input  logic                         out_ready,
   output logic [ROWS*DATA_W-1:0]       col_out,
   output logic                         col_valid,
   output logic [X_W-1:0]               x_out,
   output logic [Y_W-1:0]               y_out,
   output logic                         win_valid,
   output logic                         line_end
);

   localparam int WW   = $clog2(MAX_WIDTH) + 1;
   localparam int AW   = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam int NMEM = ROWS - 1;

   logic [WW-1:0]                 last_x;
   logic                          run;
   logic                          accept;
   logic                          flushing;
   logic                          wrap;
   logic [AW-1:0]                 ptr_q, ptr_d;
   logic [Y_W-1:0]                y_q, y_d;
   logic [DATA_W-1:0]             pix_q;
   logic                          col_valid_q;
   logic [X_W-1:0]                x_out_q;
   logic [Y_W-1:0]                y_out_q;
   logic [NMEM-1:0]               slice_en_q, slice_en_d;
   logic                          fwd_q;
   logic [NMEM-1:0][DATA_W-1:0]   fwd_data_q;
   logic                          wr_pend_q;
   logic [AW-1:0]                 wr_addr_q;
   logic [NMEM-1:0][DATA_W-1:0]   rdata, rd_eff, wdata;
   logic                          mem_we;
   logic [AW-1:0]                 mem_waddr;

   always_comb begin
      if (img_width == '0 || img_width > WW'(MAX_WIDTH)) last_x = WW'(MAX_WIDTH - 1);
      else                                               last_x = img_width - WW'(1);
   end

`ifdef LBUF_FLUSH_SWEEP_EN
   localparam int unsigned SWEEP_LEN = lbuf_sweep_len(MAX_WIDTH);

   lbuf_state_e   state_q;
   logic [AW-1:0] flush_addr_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_FLUSH;
         flush_addr_q <= '0;
      end else if (clear) begin
         state_q      <= ST_FLUSH;
         flush_addr_q <= '0;
      end else if (state_q == ST_FLUSH) begin
         flush_addr_q <= flush_addr_q + AW'(1);
         if (flush_addr_q == AW'(SWEEP_LEN - 1)) begin
            state_q      <= ST_RUN;
            flush_addr_q <= '0;
         end
      end
   end

   assign run       = (state_q == ST_RUN);
   assign flushing  = (state_q == ST_FLUSH);
   assign mem_we    = flushing || wr_pend_q;
   assign mem_waddr = flushing ? flush_addr_q : wr_addr_q;
`else
   logic run_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     run_q <= 1'b0;
      else if (clear) run_q <= 1'b0;
      else            run_q <= 1'b1;
   end

   assign run       = run_q;
   assign flushing  = 1'b0;
   assign mem_we    = wr_pend_q;
   assign mem_waddr = wr_addr_q;
`endif

   // A coincident clear must win, so ready drops for that cycle.
   assign pixel_ready = run && (!col_valid_q || out_ready) && !clear;
   assign accept      = pixel_valid && pixel_ready;

   assign wrap  = (WW'(ptr_q) == last_x);
   assign ptr_d = wrap ? '0 : ptr_q + AW'(1);
   assign y_d   = (wrap && y_q != '1) ? y_q + Y_W'(1) : y_q;

   // Line shifting is written one cycle after the read, so a same-address
   // re-read (one-pixel lines) takes the pending data instead of the RAM.
   assign rd_eff = fwd_q ? fwd_data_q : rdata;

   always_comb begin
      wdata = '0;
      if (!flushing) begin
         for (int r = 0; r < NMEM - 1; r++) wdata[r] = rd_eff[r+1];
         wdata[NMEM-1] = pix_q;
      end
   end

   always_comb begin
      slice_en_d = '0;
      for (int r = 0; r < NMEM; r++) begin
`ifdef LBUF_FLUSH_SWEEP_EN
         slice_en_d[r] = 1'b1;
`else
         slice_en_d[r] = (int'(y_q) >= ROWS - 1 - r);
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q       <= '0;
         y_q         <= '0;
         pix_q       <= '0;
         col_valid_q <= 1'b0;
         x_out_q     <= '0;
         y_out_q     <= '0;
         slice_en_q  <= '0;
         fwd_q       <= 1'b0;
         fwd_data_q  <= '0;
         wr_pend_q   <= 1'b0;
         wr_addr_q   <= '0;
      end else if (clear) begin
         ptr_q       <= '0;
         y_q         <= '0;
         pix_q       <= '0;
         col_valid_q <= 1'b0;
         x_out_q     <= '0;
         y_out_q     <= '0;
         slice_en_q  <= '0;
         fwd_q       <= 1'b0;
         wr_pend_q   <= 1'b0;
      end else begin
         wr_pend_q <= accept;
         if (accept) begin
            ptr_q       <= ptr_d;
            y_q         <= y_d;
            pix_q       <= pixel_in;
            col_valid_q <= 1'b1;
            x_out_q     <= X_W'(ptr_q);
            y_out_q     <= y_q;
            slice_en_q  <= slice_en_d;
            fwd_q       <= wr_pend_q && (wr_addr_q == ptr_q);
            fwd_data_q  <= wdata;
            wr_addr_q   <= ptr_q;
         end else if (out_ready) begin
            col_valid_q <= 1'b0;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NMEM; gi++) begin : g_line
         lbuf_line_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (MAX_WIDTH),
            .AW     (AW)
         ) u_ram (
            .clk     (clk),
            .re_i    (accept),
            .raddr_i (ptr_q),
            .rdata_o (rdata[gi]),
            .we_i    (mem_we),
            .waddr_i (mem_waddr),
            .wdata_i (wdata[gi])
         );
      end
   endgenerate

   always_comb begin
      col_out = '0;
      for (int r = 0; r < NMEM; r++)
         col_out[r*DATA_W +: DATA_W] = slice_en_q[r] ? rd_eff[r] : '0;
      col_out[NMEM*DATA_W +: DATA_W] = pix_q;
   end

   assign col_valid = col_valid_q;
   assign x_out     = x_out_q;
   assign y_out     = y_out_q;
   assign win_valid = col_valid_q && (int'(x_out_q) >= ROWS - 1) && (int'(y_out_q) >= ROWS - 1);
   assign line_end  = col_valid_q && (WW'(x_out_q) == last_x);

endmodule

// File: tb/tb_multi_line_buffer.sv
// Bench for multi_line_buffer (ROWS=3, MAX_WIDTH=8): an image-level model
// checked every cycle, plus directed streams with hand-computed columns.
module tb_multi_line_buffer;

   localparam int DATA_W = 8;
   localparam int MAXW   = 8;
   localparam int ROWS   = 3;
`ifdef LBUF_FLUSH_SWEEP_EN
   localparam int FLUSH_CYC = MAXW;
`else
   localparam int FLUSH_CYC = 1;
`endif

   logic                     clk = 1'b0;
   logic                     reset = 1'b0;
   logic                     clear = 1'b0;
   logic [3:0]               img_width = 4'd4;
   logic [DATA_W-1:0]        pixel_in = '0;
   logic                     pixel_valid = 1'b0;
   logic                     pixel_ready;
   logic                     out_ready = 1'b1;
   logic [ROWS*DATA_W-1:0]   col_out;
   logic                     col_valid;
   logic [10:0]              x_out;
   logic [9:0]               y_out;
   logic                     win_valid;
   logic                     line_end;

   multi_line_buffer #(
      .DATA_W(DATA_W), .MAX_WIDTH(MAXW), .ROWS(ROWS), .X_W(11), .Y_W(10)
   ) dut (
      .clk(clk), .reset(reset), .clear(clear), .img_width(img_width),
      .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
      .out_ready(out_ready), .col_out(col_out), .col_valid(col_valid),
      .x_out(x_out), .y_out(y_out), .win_valid(win_valid), .line_end(line_end)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Image model: every accepted pixel stored at (row, column) since last clear
   int           frame [0:15][0:MAXW-1];
   int           m_flush, m_w, m_cx, m_cy, m_x, m_y;
   bit           m_valid, m_zero, m_acc;
   logic [23:0]  m_col;

   task automatic m_restart();
      int iw;
      iw      = int'(img_width);
      m_w     = (iw == 0 || iw > MAXW) ? MAXW : iw;
      m_flush = FLUSH_CYC;
      m_cx = 0; m_cy = 0; m_x = 0; m_y = 0;
      m_valid = 0; m_zero = 1; m_col = '0;
   endtask

   always @(negedge clk) begin
      bit exp_ready;
      if (!reset) begin
         chk("rst_pixel_ready", pixel_ready, 0);
         chk("rst_col_valid", col_valid, 0);
         chk("rst_col_out", col_out, 0);
         chk("rst_xy", {x_out, y_out}, 0);
         m_restart();
         m_acc = 0;
      end else begin
         exp_ready = (m_flush == 0) && (!m_valid || out_ready) && !clear;
         chk("pixel_ready", pixel_ready, exp_ready);
         chk("col_valid", col_valid, m_valid);
         chk("win_valid", win_valid, m_valid && m_x >= ROWS - 1 && m_y >= ROWS - 1);
         chk("line_end", line_end, m_valid && m_x == m_w - 1);
         if (m_valid || m_zero) begin
            chk("col_out", col_out, m_col);
            chk("x_out", x_out, m_x);
            chk("y_out", y_out, m_y);
         end
         m_acc = 0;
         if (clear) begin
            m_restart();
         end else begin
            if (m_flush > 0) m_flush--;
            if (pixel_valid && exp_ready) begin
               m_acc = 1;
               if (m_cy < 16) frame[m_cy][m_cx] = int'(pixel_in);
               for (int r = 0; r < ROWS; r++)
                  m_col[r*8 +: 8] = (m_cy >= ROWS - 1 - r && m_cy < 16)
                                    ? 8'(frame[m_cy-(ROWS-1-r)][m_cx]) : 8'h00;
               m_x = m_cx; m_y = m_cy;
               m_valid = 1; m_zero = 0;
               m_cx++;
               if (m_cx == m_w) begin m_cx = 0; m_cy++; end
            end else if (out_ready) begin
               m_valid = 0;
            end
         end
      end
   end

   logic [23:0] s_col;
   logic [10:0] s_x;
   logic [9:0]  s_y;
   logic        s_win, s_le;

   task automatic send(input int p);
      bit ok;
      ok = 0;
      pixel_in = 8'(p); pixel_valid = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         if (m_acc) begin ok = 1; break; end
      end
      #1;
      if (!ok) begin
         n_cmp++; n_fail++;
         $display("FAIL send_timeout: pixel %0d not accepted within 40 cycles", p);
      end
      s_col = col_out; s_x = x_out; s_y = y_out; s_win = win_valid; s_le = line_end;
      pixel_valid = 1'b0;
   endtask

   task automatic do_clear(input int w);
      @(posedge clk); #1;
      img_width = 4'(w); clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n_low;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // Not ready during the flush, then ready with all outputs idle
      n_low = 0;
      for (int i = 0; i < 20 && !pixel_ready; i++) begin
         n_low++;
         @(posedge clk); #1;
      end
      chk("flush_cycles", n_low, FLUSH_CYC);
      chk("idle_col_out", col_out, 0);
      chk("idle_col_valid", col_valid, 0);

      // Width-4 stream 1..12
      for (int p = 1; p <= 12; p++) begin
         send(p);
         chk($sformatf("line_end_p%0d", p), s_le, (p % 4 == 0));
         if (p == 9) begin
            chk("p9_col", s_col, 24'h090501);
            chk("p9_xy", {s_x, s_y}, {11'd0, 10'd2});
            chk("p9_win", s_win, 0);
         end
         if (p == 11) begin
            chk("p11_col", s_col, 24'h0B0703);
            chk("p11_win", s_win, 1);
         end
      end

      // Back-pressure after pixel 5
      do_clear(4);
      for (int p = 1; p <= 5; p++) send(p);
      out_ready = 1'b0; pixel_in = 8'd6; pixel_valid = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("hold_col", col_out[23:16], 5);
         chk("hold_valid", col_valid, 1);
         chk("hold_ready", pixel_ready, 0);
      end
      out_ready = 1'b1;
      send(6);
      chk("p6_col_top", s_col[23:16], 6);
      chk("p6_xy", {s_x, s_y}, {11'd1, 10'd1});
      send(7);
      send(8);
      chk("p8_col", s_col, 24'h080400);

      // Clear mid-image: upper slices must read zero afterwards
      do_clear(4);
      for (int p = 1; p <= 6; p++) send(p);
      do_clear(4);
      for (int p = 1; p <= 4; p++) begin
         send(p);
         chk($sformatf("post_clear_low_p%0d", p), s_col[15:0], 0);
         chk($sformatf("post_clear_top_p%0d", p), s_col[23:16], p);
         chk($sformatf("post_clear_y_p%0d", p), s_y, 0);
      end

      // img_width 0 means full MAX_WIDTH
      do_clear(0);
      for (int p = 1; p <= 9; p++) begin
         send(p);
         if (p == 8) chk("w0_p8_x", s_x, 7);
         if (p == 9) begin
            chk("w0_p9_xy", {s_x, s_y}, {11'd0, 10'd1});
            chk("w0_p9_r1", s_col[15:8], 1);
            chk("w0_p9_r0", s_col[7:0], 0);
         end
      end

      // Clear coincident with a valid pixel: pixel dropped
      @(posedge clk); #1;
      img_width = 4'd4; clear = 1'b1; pixel_in = 8'hAA; pixel_valid = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0; pixel_valid = 1'b0;
      chk("clr_pix_valid", col_valid, 0);
      chk("clr_pix_col", col_out, 0);
      repeat (FLUSH_CYC + 2) @(posedge clk);
      #1;
      chk("clr_pix_valid_late", col_valid, 0);
      send(8'h11);
      chk("clr_next_col", s_col, 24'h110000);
      chk("clr_next_xy", {s_x, s_y}, 0);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
